// File: rtl/vga_cap_pkg.sv
// Shared constants and types for the VGA frame capture block.
package vga_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;
  localparam int PIX_W   = RED_W + GREEN_W + BLUE_W;
  localparam int CSUM_W  = 24;
  localparam int HSC_W   = 10;

  // Polarity 0 means the sync pulse is driven low.
  function automatic logic sync_active_level(input int pol);
    return (pol != 0);
  endfunction

  function automatic logic sync_inactive_level(input int pol);
    return (pol == 0);
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Rise/fall detector that only advances on pixel strobes, so edges are seen
// solely when the sampled level differs from the previous sampled level.
module vga_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic sig,
  input  logic rst_level,
  output logic rise,
  output logic fall
);

  logic prev;

  // Previous sample, loaded with the idle level of the line at reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= rst_level;
    end else if (pix_en) begin
      prev <= sig;
    end
  end

  assign rise = pix_en & sig & ~prev;
  assign fall = pix_en & ~sig & prev;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one active VGA frame into a RAM write port, with checksum and
// line/frame timing error flags.
module vga_frame_capture
  import vga_cap_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int SYNC_POL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_en,
  input  logic [RED_W-1:0]     red,
  input  logic [GREEN_W-1:0]   green,
  input  logic [BLUE_W-1:0]    blue,
  input  logic                 Hsync,
  input  logic                 Vsync,
  input  logic                 VGA_blank_n,
  input  logic                 arm,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [PIX_W-1:0]     wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 line_err,
  output logic                 frame_err,
  output logic [CSUM_W-1:0]    checksum,
  output logic [HSC_W-1:0]     hs_count
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_MAX    = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX    = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_ACTIVE);
  localparam logic              SYNC_ACT = sync_active_level(SYNC_POL);
  localparam logic              SYNC_INA = sync_inactive_level(SYNC_POL);

  state_t state, state_next;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [YW-1:0]     y_inc;
  logic [YW-1:0]     y_closed;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] line_base;
  logic [PIX_W-1:0]  pix;

  logic hs_rise, hs_fall, vs_rise, vs_fall, bl_rise, bl_fall;
  logic hs_lead, vs_lead, vs_trail;
  logic unused_edges;

  logic do_arm, do_write, do_close, do_end, do_hs, pix_err;

  vga_edge_det u_hs_edge (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .sig       (Hsync),
    .rst_level (SYNC_INA),
    .rise      (hs_rise),
    .fall      (hs_fall)
  );

  vga_edge_det u_vs_edge (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .sig       (Vsync),
    .rst_level (SYNC_INA),
    .rise      (vs_rise),
    .fall      (vs_fall)
  );

  vga_edge_det u_bl_edge (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .sig       (VGA_blank_n),
    .rst_level (1'b0),
    .rise      (bl_rise),
    .fall      (bl_fall)
  );

  assign hs_lead  = SYNC_ACT ? hs_rise : hs_fall;
  assign vs_lead  = SYNC_ACT ? vs_rise : vs_fall;
  assign vs_trail = SYNC_ACT ? vs_fall : vs_rise;
  // Hsync trailing edges and blank_n rising edges carry no meaning here.
  assign unused_edges = (SYNC_ACT ? hs_fall : hs_rise) ^ bl_rise;

  assign pix      = {red, green, blue};
  assign y_inc    = (y == '1) ? y : y + 1'b1;
  // Frame-end check sees the line count after a same-sample line close.
  assign y_closed = do_close ? y_inc : y;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-sample action decode.
  always_comb begin
    state_next = state;
    do_arm     = 1'b0;
    do_write   = 1'b0;
    do_close   = 1'b0;
    do_end     = 1'b0;
    do_hs      = 1'b0;
    pix_err    = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          do_arm     = 1'b1;
          state_next = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (vs_trail) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bl_fall) begin
          do_close = 1'b1;
        end else if (pix_en && VGA_blank_n) begin
          if ((x < X_MAX) && (y < Y_MAX)) begin
            do_write = 1'b1;
          end else begin
            pix_err = 1'b1;
          end
        end
        do_hs = hs_lead;
        if (vs_lead) begin
          do_end     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, address generation, write port, checksum and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      checksum  <= '0;
      hs_count  <= '0;
      x         <= '0;
      y         <= '0;
      addr_cnt  <= '0;
      line_base <= '0;
    end else begin
      wr_en <= do_write;
      done  <= do_end;
      if (do_write) begin
        wr_addr  <= addr_cnt;
        wr_data  <= pix;
        addr_cnt <= addr_cnt + 1'b1;
        x        <= x + 1'b1;
        checksum <= checksum + CSUM_W'(pix);
      end
      if (do_close) begin
        x <= '0;
        y <= y_inc;
        // Next line starts at its own base so short lines do not skew addresses.
        if (y < Y_MAX) begin
          line_base <= line_base + H_STEP;
          addr_cnt  <= line_base + H_STEP;
        end
        if (x != X_MAX) begin
          line_err <= 1'b1;
        end
      end
      if (pix_err) begin
        line_err <= 1'b1;
      end
      if (do_hs && (hs_count != '1)) begin
        hs_count <= hs_count + 1'b1;
      end
      if (do_end && (y_closed != Y_MAX)) begin
        frame_err <= 1'b1;
      end
      if (do_arm) begin
        line_err  <= 1'b0;
        frame_err <= 1'b0;
        checksum  <= '0;
        hs_count  <= '0;
        x         <= '0;
        y         <= '0;
        addr_cnt  <= '0;
        line_base <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture with a small 8x4 frame.
module tb_vga_frame_capture;

  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_en = 1'b0;
  logic [2:0]    red = '0;
  logic [2:0]    green = '0;
  logic [1:0]    blue = '0;
  logic          Hsync = 1'b1;
  logic          Vsync = 1'b1;
  logic          VGA_blank_n = 1'b0;
  logic          arm = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          line_err;
  logic          frame_err;
  logic [23:0]   checksum;
  logic [9:0]    hs_count;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [13:0] sb[$];
  int exp_sum = 0;
  int exp_hs = 0;
  bit exp_le = 0;
  bit exp_fe = 0;

  vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SYNC_POL(0)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .red(red), .green(green), .blue(blue),
    .Hsync(Hsync), .Vsync(Vsync), .VGA_blank_n(VGA_blank_n), .arm(arm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .line_err(line_err), .frame_err(frame_err), .checksum(checksum), .hs_count(hs_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {26'd0, wr_addr}, 32'hffff_ffff);
      end else begin
        logic [13:0] e;
        e = sb.pop_front();
        chk("wr_addr", {26'd0, wr_addr}, {26'd0, e[13:8]});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
    if (!reset && done) done_cnt++;
  end

  // One pixel strobe followed by one idle clock.
  task automatic px(input logic [7:0] d, input logic hs, input logic vs, input logic bl);
    @(negedge clk);
    {red, green, blue} = d;
    Hsync = hs; Vsync = vs; VGA_blank_n = bl;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  // Change levels on non-strobe cycles and hold them for n clocks.
  task automatic set_off(input logic hs, input logic vs, input logic bl, input int n);
    @(negedge clk);
    pix_en = 1'b0;
    Hsync = hs; Vsync = vs; VGA_blank_n = bl;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_arm();
    pulse_arm();
    exp_sum = 0; exp_hs = 0; exp_le = 0; exp_fe = 0;
    chk("arm_busy", {31'd0, busy}, 1);
    chk("arm_checksum", {8'd0, checksum}, 0);
    chk("arm_line_err", {31'd0, line_err}, 0);
    chk("arm_frame_err", {31'd0, frame_err}, 0);
    chk("arm_hs_count", {22'd0, hs_count}, 0);
  endtask

  task automatic frame(input int nlines, input int short_l, input int short_len,
                       input int arm_l, input bit late);
    int d0;
    int len;
    logic [7:0] d;
    d0 = done_cnt;
    px(8'd0, 1'b1, 1'b0, 1'b0);
    px(8'd0, 1'b1, 1'b0, 1'b0);
    if (late) set_off(1'b1, 1'b1, 1'b0, 3);
    px(8'd0, 1'b1, 1'b1, 1'b0);
    px(8'd0, 1'b1, 1'b1, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_l) ? short_len : H;
      if (l == arm_l) begin
        pulse_arm();
        chk("arm_ignored_busy", {31'd0, busy}, 1);
      end
      px(8'd0, 1'b0, 1'b1, 1'b0);
      px(8'd0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < len; k++) begin
        d = 8'(l * H + k);
        if (l < V && k < H) begin
          sb.push_back({6'(l * H + k), d});
          exp_sum += d;
        end
        px(d, 1'b1, 1'b1, 1'b1);
      end
      if (late) set_off(1'b1, 1'b1, 1'b0, 2);
      px(8'd0, 1'b1, 1'b1, 1'b0);
      if (len != H || l >= V) exp_le = 1;
      exp_hs++;
    end
    px(8'd0, 1'b1, 1'b1, 1'b0);
    if (late) begin
      set_off(1'b1, 1'b0, 1'b0, 3);
      chk("late_no_done", done_cnt, d0);
      chk("late_busy", {31'd0, busy}, 1);
    end
    px(8'd0, 1'b1, 1'b0, 1'b0);
    if (nlines != V) exp_fe = 1;
    chk("done_pulse", {31'd0, done}, 1);
    @(negedge clk);
    chk("done_single", {31'd0, done}, 0);
    chk("done_count", done_cnt, d0 + 1);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("sb_empty", sb.size(), 0);
    chk("checksum", {8'd0, checksum}, exp_sum & 32'hff_ffff);
    chk("line_err", {31'd0, line_err}, {31'd0, exp_le});
    chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
    chk("hs_count", {22'd0, hs_count}, exp_hs);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
    chk({tag, "_wr_addr"}, {26'd0, wr_addr}, 0);
    chk({tag, "_wr_data"}, {24'd0, wr_data}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_line_err"}, {31'd0, line_err}, 0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 0);
    chk({tag, "_checksum"}, {8'd0, checksum}, 0);
    chk({tag, "_hs_count"}, {22'd0, hs_count}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_zero("por");

    // Reset in the middle of a capture.
    do_arm();
    px(8'd0, 1'b1, 1'b0, 1'b0);
    px(8'd0, 1'b1, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b1, 1'b0);
    px(8'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sb.push_back({6'(k), 8'(k + 5)});
      px(8'(k + 5), 1'b1, 1'b1, 1'b1);
    end
    chk("pre_reset_busy", {31'd0, busy}, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_zero("mid_reset");
    d0 = done_cnt;
    px(8'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("no_partial_done", done_cnt, d0);
    chk("reset_sb_empty", sb.size(), 0);

    // Full frame, pixel value equals address.
    do_arm();
    frame(V, -1, 0, -1, 1'b0);
    chk("full_sum_496", {8'd0, checksum}, 496);

    // One short line.
    do_arm();
    frame(V, 1, 7, -1, 1'b0);

    // One line too many.
    do_arm();
    frame(V + 1, -1, 0, -1, 1'b0);

    // Arm while busy is ignored; flags survive to done.
    do_arm();
    frame(V, 0, 7, 2, 1'b0);
    chk("busy_arm_kept_err", {31'd0, line_err}, 1);

    // Re-arm after done, then edges launched between strobes.
    do_arm();
    frame(V, -1, 0, -1, 1'b1);
    chk("late_sum_496", {8'd0, checksum}, 496);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
